// File: rtl/lgdst_spi3w_bridge.sv
// Oversampling bridge from a 4-wire host SPI port to NUM_SLV 3-wire slaves on one shared SDIO line.
// Decodes the R/W bit of the instruction phase, turns SDIO around for reads and flags protocol errors.
//
// state | meaning
// IDLE  | no chip select active, slaves deselected
// CMD   | instruction phase: counting sclk rises, capturing the R/W bit
// WR    | host owns SDIO, data streamed through for any length
// RD    | SDIO released, slave data returned on spi0_miso
// ERR   | protocol error, slaves deselected until every host CS is high
module lgdst_spi3w_bridge #(
    parameter int NUM_SLV     = 2,
    parameter int CMD_BITS    = 16,
    parameter int RW_BIT_POS  = 0,
    parameter bit RD_POL      = 1'b1,
    parameter int SYNC_STAGES = 2,
    parameter int TO_CYCLES   = 4096
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               spi0_clk,
    input  logic [NUM_SLV-1:0] spi0_cs,
    input  logic               spi0_mosi,
    output logic               spi0_miso,
    output logic               ad_spi_sclk,
    output logic [NUM_SLV-1:0] ad_spi_cs,
    output logic               ad_spi_sdio_o,
    output logic               ad_spi_sdio_oe,
    input  logic               ad_spi_sdio_i,
    output logic               busy,
    output logic               rd_active,
    output logic               xfer_done,
    output logic               err_multi_cs,
    output logic               err_timeout,
    output logic [15:0]        xfer_cnt
);

    localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
    localparam int BIT_W = $clog2(CMD_BITS + 1);
    localparam int WD_W  = $clog2(TO_CYCLES);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WR,
        ST_RD,
        ST_ERR
    } state_t;

    state_t state, state_nxt;

    logic [SYNC_STAGES-1:0]              clk_sync;
    logic [SYNC_STAGES-1:0]              mosi_sync;
    logic [SYNC_STAGES-1:0][NUM_SLV-1:0] cs_sync;

    logic               s_clk;
    logic               s_mosi;
    logic [NUM_SLV-1:0] s_cs;
    logic [NUM_SLV-1:0] cs_low;

    logic sclk_q;
    logic mosi_q;
    logic sclk_rise;
    logic sclk_fall;
    logic sclk_edge;

    logic [IDX_W-1:0] sel_idx, idx_nxt, first_idx;
    logic [BIT_W-1:0] bitcnt, bitcnt_nxt;
    logic             rw, rw_nxt;
    logic [WD_W-1:0]  wd_cnt;

    logic               one_low;
    logic               sel_cs_high;
    logic               active;
    logic               active_nxt;
    logic               wd_expired;
    logic               done_nxt;
    logic               multi_nxt;
    logic               to_nxt;
    logic [NUM_SLV-1:0] sel_mask_nxt;

    // Every host input goes through the same depth so their relative timing is kept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            clk_sync  <= '0;
            mosi_sync <= '0;
            cs_sync   <= '1;
        end else begin
            clk_sync  <= {clk_sync[SYNC_STAGES-2:0], spi0_clk};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi0_mosi};
            cs_sync   <= {cs_sync[SYNC_STAGES-2:0], spi0_cs};
        end
    end

    assign s_clk  = clk_sync[SYNC_STAGES-1];
    assign s_mosi = mosi_sync[SYNC_STAGES-1];
    assign s_cs   = cs_sync[SYNC_STAGES-1];
    assign cs_low = ~s_cs;

    assign sclk_rise = s_clk & ~sclk_q;
    assign sclk_fall = ~s_clk & sclk_q;
    assign sclk_edge = sclk_rise | sclk_fall;

    assign one_low     = (cs_low != '0) && ((cs_low & (cs_low - NUM_SLV'(1))) == '0);
    assign sel_cs_high = s_cs[sel_idx];
    assign active      = (state == ST_CMD) || (state == ST_WR) || (state == ST_RD);
    assign wd_expired  = active && (wd_cnt == '0) && !sclk_edge;

    always_comb begin
        first_idx = '0;
        for (int i = NUM_SLV - 1; i >= 0; i--) begin
            if (cs_low[i]) first_idx = IDX_W'(i);
        end
    end

    always_comb begin
        state_nxt  = state;
        idx_nxt    = sel_idx;
        bitcnt_nxt = bitcnt;
        rw_nxt     = rw;
        done_nxt   = 1'b0;
        multi_nxt  = 1'b0;
        to_nxt     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (one_low) begin
                    state_nxt  = ST_CMD;
                    idx_nxt    = first_idx;
                    bitcnt_nxt = '0;
                end else if (cs_low != '0) begin
                    state_nxt = ST_ERR;
                    multi_nxt = 1'b1;
                end
            end
            ST_CMD, ST_WR, ST_RD: begin
                // CS release outranks both the watchdog and any sclk edge in the same cycle.
                if (sel_cs_high) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = (bitcnt != '0);
                end else if (wd_expired) begin
                    state_nxt = ST_ERR;
                    to_nxt    = 1'b1;
                end else if (state == ST_CMD) begin
                    if (sclk_rise) begin
                        if (bitcnt == BIT_W'(RW_BIT_POS)) rw_nxt = s_mosi;
                        if (bitcnt != BIT_W'(CMD_BITS)) bitcnt_nxt = bitcnt + BIT_W'(1);
                    end else if (sclk_fall && (bitcnt == BIT_W'(CMD_BITS))) begin
                        state_nxt = (rw == RD_POL) ? ST_RD : ST_WR;
                    end
                end
            end
            ST_ERR: begin
                if (&s_cs) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign active_nxt   = (state_nxt == ST_CMD) || (state_nxt == ST_WR) || (state_nxt == ST_RD);
    assign sel_mask_nxt = NUM_SLV'(1) << idx_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state          <= ST_IDLE;
            sel_idx        <= '0;
            bitcnt         <= '0;
            rw             <= 1'b0;
            wd_cnt         <= WD_W'(TO_CYCLES - 1);
            sclk_q         <= 1'b0;
            mosi_q         <= 1'b0;
            ad_spi_cs      <= '1;
            ad_spi_sdio_oe <= 1'b0;
            xfer_done      <= 1'b0;
            err_multi_cs   <= 1'b0;
            err_timeout    <= 1'b0;
            xfer_cnt       <= '0;
        end else begin
            state   <= state_nxt;
            sel_idx <= idx_nxt;
            bitcnt  <= bitcnt_nxt;
            rw      <= rw_nxt;
            sclk_q  <= s_clk;
            mosi_q  <= s_mosi;
            // Watchdog: down-counter reloaded on every sclk edge and whenever no transfer is active.
            if (!active || sclk_edge) wd_cnt <= WD_W'(TO_CYCLES - 1);
            else if (wd_cnt != '0)    wd_cnt <= wd_cnt - WD_W'(1);
            ad_spi_cs      <= active_nxt ? (s_cs | ~sel_mask_nxt) : '1;
            ad_spi_sdio_oe <= (state_nxt == ST_CMD) || (state_nxt == ST_WR);
            xfer_done      <= done_nxt;
            err_multi_cs   <= multi_nxt;
            err_timeout    <= to_nxt;
            if (done_nxt) xfer_cnt <= xfer_cnt + 16'd1;
        end
    end

    assign ad_spi_sclk   = sclk_q;
    assign ad_spi_sdio_o = mosi_q;
    assign spi0_miso     = (state == ST_RD) ? ad_spi_sdio_i : 1'b0;
    assign busy          = (state != ST_IDLE);
    assign rd_active     = (state == ST_RD);

endmodule

// File: tb/tb_lgdst_spi3w_bridge.sv
// Randomized bench for lgdst_spi3w_bridge: host SPI driver, 3-wire slave model and an event scoreboard.
module tb_lgdst_spi3w_bridge;

    localparam int NS         = 2;
    localparam int CMD_BITS   = 16;
    localparam int RW_BIT_POS = 0;
    localparam bit RD_POL     = 1'b1;
    localparam int SYNC       = 2;
    localparam int TO_CYC     = 4096;
    localparam int HALF       = 8;

    localparam int EV_DONE    = 0;
    localparam int EV_MULTI   = 1;
    localparam int EV_TIMEOUT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          spi0_clk = 1'b0;
    logic [NS-1:0] spi0_cs = '1;
    logic          spi0_mosi = 1'b0;
    logic          spi0_miso;
    logic          ad_spi_sclk;
    logic [NS-1:0] ad_spi_cs;
    logic          ad_spi_sdio_o;
    logic          ad_spi_sdio_oe;
    logic          ad_spi_sdio_i = 1'b0;
    logic          busy;
    logic          rd_active;
    logic          xfer_done;
    logic          err_multi_cs;
    logic          err_timeout;
    logic [15:0]   xfer_cnt;

    lgdst_spi3w_bridge #(
        .NUM_SLV    (NS),
        .CMD_BITS   (CMD_BITS),
        .RW_BIT_POS (RW_BIT_POS),
        .RD_POL     (RD_POL),
        .SYNC_STAGES(SYNC),
        .TO_CYCLES  (TO_CYC)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .spi0_clk      (spi0_clk),
        .spi0_cs       (spi0_cs),
        .spi0_mosi     (spi0_mosi),
        .spi0_miso     (spi0_miso),
        .ad_spi_sclk   (ad_spi_sclk),
        .ad_spi_cs     (ad_spi_cs),
        .ad_spi_sdio_o (ad_spi_sdio_o),
        .ad_spi_sdio_oe(ad_spi_sdio_oe),
        .ad_spi_sdio_i (ad_spi_sdio_i),
        .busy          (busy),
        .rd_active     (rd_active),
        .xfer_done     (xfer_done),
        .err_multi_cs  (err_multi_cs),
        .err_timeout   (err_timeout),
        .xfer_cnt      (xfer_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         kind;
        logic [15:0] cnt;
        bit         rd;
        logic [7:0] rdata;
    } ev_t;

    ev_t         exp_q[$];
    logic [15:0] model_cnt = '0;
    logic [7:0]  host_rdata = '0;
    logic [7:0]  slave_data [NS];
    int          checks = 0;
    int          errors = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void push_ev(input int kind, input bit rd, input logic [7:0] rdata);
        ev_t e;
        e.kind  = kind;
        e.cnt   = model_cnt;
        e.rd    = rd;
        e.rdata = rdata;
        exp_q.push_back(e);
    endfunction

    function automatic void got(input int kind);
        ev_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL event_unexpected: got kind %0d, expected no event at %0t", kind, $time);
            return;
        end
        e = exp_q.pop_front();
        chk("event_kind", 32'(kind), 32'(e.kind));
        chk("xfer_cnt", 32'(xfer_cnt), 32'(e.cnt));
        if (e.rd) chk("read_data", 32'(host_rdata), 32'(e.rdata));
    endfunction

    // Monitor: every pulse the DUT emits must match the next expected event.
    always @(negedge clk) begin
        if (xfer_done)    got(EV_DONE);
        if (err_multi_cs) got(EV_MULTI);
        if (err_timeout)  got(EV_TIMEOUT);
    end

    // 3-wire slave: after CMD_BITS rising edges it drives its byte MSB first on each falling edge.
    logic sl_sclk_q = 1'b0;
    int   sl_rises = 0;
    always @(negedge clk) begin
        int idx;
        if (&ad_spi_cs) begin
            sl_rises      = 0;
            ad_spi_sdio_i = 1'b0;
        end else begin
            if (ad_spi_sclk && !sl_sclk_q) sl_rises++;
            if (!ad_spi_sclk && sl_sclk_q && sl_rises >= CMD_BITS) begin
                idx = sl_rises - CMD_BITS;
                ad_spi_sdio_i = (idx < 8) ? slave_data[(ad_spi_cs == 2'b10) ? 0 : 1][7-idx] : 1'b0;
            end
        end
        sl_sclk_q = ad_spi_sclk;
    end

    task automatic send_bits(input int slv, input int nbits, input logic [63:0] bits, input bit is_rd);
        logic [NS-1:0] exp_cs;
        bit            in_rd;
        exp_cs = ~(NS'(1) << slv);
        for (int i = 0; i < nbits; i++) begin
            in_rd = is_rd && (i >= CMD_BITS);
            spi0_mosi = bits[i];
            repeat (HALF) @(negedge clk);
            chk("busy_in_xfer", 32'(busy), 32'd1);
            chk("ad_cs_in_xfer", 32'(ad_spi_cs), 32'(exp_cs));
            chk("oe_phase", 32'(ad_spi_sdio_oe), in_rd ? 32'd0 : 32'd1);
            chk("rd_active_phase", 32'(rd_active), in_rd ? 32'd1 : 32'd0);
            if (in_rd && i < CMD_BITS + 8) host_rdata = {host_rdata[6:0], spi0_miso};
            spi0_clk = 1'b1;
            repeat (HALF) @(negedge clk);
            spi0_clk = 1'b0;
        end
    endtask

    task automatic do_xfer(input int slv, input int nbits, input logic [63:0] bits, input bit hold);
        bit         is_rd;
        int         rb;
        logic [7:0] exp_rd;
        is_rd  = (nbits > CMD_BITS) && (bits[RW_BIT_POS] == RD_POL) && !hold;
        rb     = is_rd ? (((nbits - CMD_BITS) > 8) ? 8 : (nbits - CMD_BITS)) : 0;
        exp_rd = (rb > 0) ? 8'(slave_data[slv] >> (8 - rb)) : 8'h00;
        host_rdata = '0;
        if (hold) begin
            push_ev(EV_TIMEOUT, 1'b0, 8'h00);
        end else if (nbits > 0) begin
            model_cnt++;
            push_ev(EV_DONE, is_rd, exp_rd);
        end
        spi0_cs = ~(NS'(1) << slv);
        repeat (HALF) @(negedge clk);
        send_bits(slv, nbits, bits, is_rd);
        if (hold) begin
            repeat (TO_CYC + 16) @(negedge clk);
            chk("timeout_ad_cs", 32'(ad_spi_cs), 32'(2'b11));
            chk("timeout_oe", 32'(ad_spi_sdio_oe), 32'd0);
            chk("timeout_busy", 32'(busy), 32'd1);
        end
        repeat (HALF) @(negedge clk);
        spi0_cs = '1;
        repeat (HALF) @(negedge clk);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_oe", 32'(ad_spi_sdio_oe), 32'd0);
        chk("end_ad_cs", 32'(ad_spi_cs), 32'(2'b11));
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ad_cs"}, 32'(ad_spi_cs), 32'(2'b11));
        chk({tag, "_sclk"}, 32'(ad_spi_sclk), 32'd0);
        chk({tag, "_sdio_o"}, 32'(ad_spi_sdio_o), 32'd0);
        chk({tag, "_oe"}, 32'(ad_spi_sdio_oe), 32'd0);
        chk({tag, "_miso"}, 32'(spi0_miso), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_rd_active"}, 32'(rd_active), 32'd0);
        chk({tag, "_pulses"}, 32'({xfer_done, err_multi_cs, err_timeout}), 32'd0);
        chk({tag, "_xfer_cnt"}, 32'(xfer_cnt), 32'd0);
    endtask

    initial begin
        logic [63:0] b;
        slave_data[0] = 8'h00;
        slave_data[1] = 8'h00;
        repeat (4) @(negedge clk);
        chk_reset_vals("por");
        reset = 1'b1;
        repeat (4) @(negedge clk);

        // Write to slave 0, 24 bits, R/W bit 0.
        b = {$urandom, $urandom};
        b[0] = 1'b0;
        do_xfer(0, 24, b, 1'b0);

        // Read from slave 1: 16 command bits then 8 data bits of 0xA5.
        slave_data[1] = 8'hA5;
        b = {$urandom, $urandom};
        b[0] = 1'b1;
        do_xfer(1, 24, b, 1'b0);

        // Two chip selects at once.
        push_ev(EV_MULTI, 1'b0, 8'h00);
        spi0_cs = 2'b00;
        repeat (12) @(negedge clk);
        chk("multi_ad_cs", 32'(ad_spi_cs), 32'(2'b11));
        chk("multi_oe", 32'(ad_spi_sdio_oe), 32'd0);
        chk("multi_busy", 32'(busy), 32'd1);
        spi0_cs = 2'b11;
        repeat (HALF) @(negedge clk);
        chk("multi_idle", 32'(busy), 32'd0);

        // Abort after 5 bits, and a CS pulse with no clock at all.
        b = {$urandom, $urandom};
        do_xfer(0, 5, b, 1'b0);
        do_xfer(1, 0, b, 1'b0);

        // Stalled clock.
        b = {$urandom, $urandom};
        do_xfer(0, 3, b, 1'b1);

        for (int t = 0; t < 24; t++) begin
            int slv;
            int nb;
            slv = int'($urandom_range(NS - 1, 0));
            nb  = int'($urandom_range(32, 0));
            b   = {$urandom, $urandom};
            slave_data[slv] = 8'($urandom);
            do_xfer(slv, nb, b, 1'b0);
        end

        // Asynchronous reset in the middle of a read.
        slave_data[1] = 8'h3C;
        spi0_cs = 2'b01;
        repeat (HALF) @(negedge clk);
        b = {$urandom, $urandom};
        b[0] = 1'b1;
        send_bits(1, 20, b, 1'b1);
        #2 reset = 1'b0;
        #1 chk_reset_vals("midread");
        spi0_cs   = '1;
        spi0_mosi = 1'b0;
        repeat (4) @(negedge clk);
        reset     = 1'b1;
        model_cnt = '0;
        repeat (4) @(negedge clk);

        b = {$urandom, $urandom};
        b[0] = 1'b0;
        do_xfer(0, 24, b, 1'b0);

        repeat (20) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
